// File: rtl/scan_master.sv
// rtl/scan_master.sv - JTAG-style scan ring master with RTCK handshake and timeout
module scan_master #(
  parameter int CLK_DIV   = 4,
  parameter int CHAIN_LEN = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] i_pins,
  input  logic       rtck,
  input  logic       tdo,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  output logic [7:0] o_pins,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int BIT_MAX = (CHAIN_LEN > 8) ? CHAIN_LEN : 8;
  localparam int BW      = $clog2(BIT_MAX);
  localparam int CW      = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_ADDR, S_DATA, S_FLUSH, S_TRAILER, S_DONE
  } state_t;

  // Sub-phases of one TCK bit: low hold, wait rtck high, high hold, wait rtck low.
  typedef enum logic [1:0] {
    PH_LOW, PH_WAIT_HI, PH_HIGH, PH_WAIT_LO
  } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      opins_q, opins_d;
  logic            error_q, error_d;
  logic            rtck_meta_q, rtck_sync_q;
  logic            tdo_meta_q, tdo_sync_q;
  logic [BW-1:0]   bit_last;
  logic            abort;

  // Two-flop synchronizers: the only consumers of the raw ring return pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rtck_meta_q <= 1'b0;
      rtck_sync_q <= 1'b0;
      tdo_meta_q  <= 1'b0;
      tdo_sync_q  <= 1'b0;
    end else begin
      rtck_meta_q <= rtck;
      rtck_sync_q <= rtck_meta_q;
      tdo_meta_q  <= tdo;
      tdo_sync_q  <= tdo_meta_q;
    end
  end

  // Frame state, bit engine and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_LOW;
      bit_q   <= '0;
      cnt_q   <= '0;
      tck_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      opins_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tck_q   <= tck_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      opins_q <= opins_d;
      error_q <= error_d;
    end
  end

  // Index of the final bit in each sending state.
  always_comb begin
    bit_last = '0;
    case (state_q)
      S_ADDR, S_DATA: bit_last = BW'(7);
      S_FLUSH:        bit_last = BW'(CHAIN_LEN - 1);
      default:        bit_last = '0;
    endcase
  end

  // tms/tdi follow state and bit index, so they only move when a bit retires (tck and rtck low).
  always_comb begin
    tms = 1'b0;
    tdi = 1'b0;
    case (state_q)
      S_HEADER:  begin tms = 1'b1; tdi = 1'b1; end
      S_ADDR:    tdi = addr_q[bit_q[2:0]];
      S_DATA:    tdi = data_q[bit_q[2:0]];
      S_TRAILER: tms = 1'b1;
      default:   ;
    endcase
  end

  // Next-state logic: frame sequencing, per-bit TCK handshake, capture and timeout abort.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tck_d   = tck_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cap_d   = cap_q;
    opins_d = opins_q;
    error_d = error_q;
    abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d = PH_LOW;
        cnt_d   = '0;
        bit_d   = '0;
        tck_d   = 1'b0;
        if (start) begin
          addr_d  = addr;
          data_d  = i_pins;
          error_d = 1'b0;
          state_d = S_HEADER;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        case (phase_q)
          PH_LOW: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
              tck_d   = 1'b1;
              phase_d = PH_WAIT_HI;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PH_WAIT_HI: begin
            if (rtck_sync_q) begin
              phase_d = PH_HIGH;
              cnt_d   = '0;
              if (state_q == S_DATA || state_q == S_FLUSH)
                cap_d = {tdo_sync_q, cap_q[7:1]};
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
              abort = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PH_HIGH: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
              tck_d   = 1'b0;
              phase_d = PH_WAIT_LO;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            if (!rtck_sync_q) begin
              phase_d = PH_LOW;
              cnt_d   = '0;
              if (bit_q == bit_last) begin
                bit_d = '0;
                case (state_q)
                  S_HEADER: state_d = S_ADDR;
                  S_ADDR:   state_d = S_DATA;
                  S_DATA:   state_d = S_FLUSH;
                  S_FLUSH: begin
                    state_d = S_TRAILER;
                    opins_d = cap_q;
                  end
                  default:  state_d = S_DONE;
                endcase
              end else begin
                bit_d = bit_q + BW'(1);
              end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
              abort = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        endcase
        if (abort) begin
          error_d = 1'b1;
          tck_d   = 1'b0;
          state_d = S_IDLE;
          phase_d = PH_LOW;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
    endcase
  end

  assign tck    = tck_q;
  assign o_pins = opins_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign error  = error_q;

endmodule

// File: tb/tb_scan_master.sv
// tb/tb_scan_master.sv - directed self-checking bench for scan_master
module tb_scan_master;
  localparam int CLK_DIV   = 4;
  localparam int CHAIN_LEN = 5;
  localparam int TIMEOUT   = 255;
  localparam int FRAME     = 18 + CHAIN_LEN;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] i_pins = 8'h00;
  logic       rtck, tdo, tck, tms, tdi, busy, done, error;
  logic [7:0] o_pins;
  logic       tck_f, tms_f, tdi_f, busy_f, done_f, error_f;
  logic [7:0] o_pins_f;
  logic       inv = 1'b0;
  logic       stuck = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_master #(.CLK_DIV(CLK_DIV), .CHAIN_LEN(CHAIN_LEN), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .i_pins(i_pins),
    .rtck(rtck), .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi), .o_pins(o_pins),
    .busy(busy), .done(done), .error(error)
  );

  scan_master #(.CLK_DIV(1), .CHAIN_LEN(CHAIN_LEN), .TIMEOUT(TIMEOUT)) u_fast (
    .clk(clk), .reset_n(reset_n), .start(start_f), .addr(addr), .i_pins(i_pins),
    .rtck(tck_f), .tdo(1'b1), .tck(tck_f), .tms(tms_f), .tdi(tdi_f), .o_pins(o_pins_f),
    .busy(busy_f), .done(done_f), .error(error_f)
  );

  // Ring model: TAPs sample tdi on tck rise, last stage presents tdo on tck fall.
  logic [CHAIN_LEN-1:0] ring = '0;
  logic                 tdo_reg = 1'b0;
  logic [2:0]           rdly = '0;
  always @(posedge tck) ring <= {ring[CHAIN_LEN-2:0], tdi};
  always @(negedge tck) tdo_reg <= ring[CHAIN_LEN-1];
  always @(posedge clk) rdly <= {rdly[1:0], tck};
  assign tdo  = tdo_reg ^ inv;
  assign rtck = stuck ? 1'b0 : rdly[2];

  // Observation of DUT outputs on the falling clk edge.
  int   cyc = 0;
  int   pulse_cnt = 0, done_cnt = 0, done_nobusy = 0;
  int   last_rise_cyc = 0, err_cyc = 0;
  logic tck_prev = 1'b0, err_prev = 1'b0;
  logic rise_tms [0:511];
  logic rise_tdi [0:511];
  int   pulse_f = 0, done_cnt_f = 0, run_f = 0, min_run_f = 1000, tdi_bad_f = 0;
  logic tck_f_prev = 1'b0, tdi_f_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tck_prev <= tck;
    err_prev <= error;
    if (tck && !tck_prev) begin
      rise_tms[pulse_cnt] <= tms;
      rise_tdi[pulse_cnt] <= tdi;
      pulse_cnt     <= pulse_cnt + 1;
      last_rise_cyc <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (done && !busy) done_nobusy <= done_nobusy + 1;
    if (error && !err_prev) err_cyc <= cyc;
    tck_f_prev <= tck_f;
    tdi_f_prev <= tdi_f;
    if (tck_f !== tck_f_prev) begin
      if (run_f < min_run_f) min_run_f <= run_f;
      run_f <= 1;
    end else begin
      run_f <= run_f + 1;
    end
    if (tck_f && !tck_f_prev) begin
      pulse_f <= pulse_f + 1;
      if (tdi_f !== tdi_f_prev) tdi_bad_f <= tdi_bad_f + 1;
    end
    if (done_f) done_cnt_f <= done_cnt_f + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int base);
    int i = 0;
    while (done_cnt == base && i < 4000) begin
      tick(1);
      i++;
    end
    check({tag, "_done_seen"}, int'(done_cnt != base), 1);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] d);
    addr   = a;
    i_pins = d;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int pbase, input int dbase,
                             input logic [7:0] exp_o);
    check({tag, "_pulses"},     pulse_cnt - pbase, FRAME);
    check({tag, "_first_tms"},  int'(rise_tms[pbase]), 1);
    check({tag, "_first_tdi"},  int'(rise_tdi[pbase]), 1);
    check({tag, "_last_tms"},   int'(rise_tms[pbase+FRAME-1]), 1);
    check({tag, "_last_tdi"},   int'(rise_tdi[pbase+FRAME-1]), 0);
    check({tag, "_done_count"}, done_cnt - dbase, 1);
    check({tag, "_o_pins"},     int'(o_pins), int'(exp_o));
    check({tag, "_error"},      int'(error), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_done_busy"},  done_nobusy, 0);
  endtask

  int pb, db, i;

  initial begin
    tick(5);
    check("rst_tck", int'(tck), 0);
    check("rst_tms", int'(tms), 0);
    check("rst_tdi", int'(tdi), 0);
    check("rst_o_pins", int'(o_pins), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    reset_n = 1'b1;
    tick(2);

    // Straight ring, addr 01 / data A5.
    pb = pulse_cnt; db = done_cnt;
    launch(8'h01, 8'hA5);
    check("f1_busy_after_start", int'(busy), 1);
    wait_done("f1", db);
    tick(1);
    check_frame("f1", pb, db, 8'hA5);
    check("f1_addr_b0", int'(rise_tdi[pb+1]), 1);
    check("f1_addr_b1", int'(rise_tdi[pb+2]), 0);
    check("f1_addr_tms", int'(rise_tms[pb+1]), 0);
    check("f1_data_b0", int'(rise_tdi[pb+9]), 1);
    check("f1_data_b1", int'(rise_tdi[pb+10]), 0);
    check("f1_flush_tdi", int'(rise_tdi[pb+17]), 0);

    // Inverting ring, data 3C.
    inv = 1'b1;
    pb = pulse_cnt; db = done_cnt;
    launch(8'h5A, 8'h3C);
    wait_done("f2", db);
    tick(1);
    check_frame("f2", pb, db, 8'hC3);
    inv = 1'b0;

    // rtck stuck low: timeout on first bit.
    stuck = 1'b1;
    pb = pulse_cnt; db = done_cnt;
    launch(8'h00, 8'hFF);
    i = 0;
    while (!error && i < 1000) begin tick(1); i++; end
    check("to_error", int'(error), 1);
    check("to_latency", err_cyc - last_rise_cyc, TIMEOUT);
    check("to_pulses", pulse_cnt - pb, 1);
    check("to_busy", int'(busy), 0);
    check("to_tck", int'(tck), 0);
    check("to_tms", int'(tms), 0);
    check("to_tdi", int'(tdi), 0);
    tick(20);
    check("to_no_done", done_cnt - db, 0);
    check("to_o_pins_kept", int'(o_pins), 8'hC3);
    check("to_error_sticky", int'(error), 1);
    stuck = 1'b0;
    tick(10);

    // Reset during ADDR bit 4, then a fresh frame.
    pb = pulse_cnt; db = done_cnt;
    launch(8'h10, 8'h66);
    check("rs_error_cleared", int'(error), 0);
    i = 0;
    while (pulse_cnt < pb + 6 && i < 2000) begin tick(1); i++; end
    check("rs_reached_bit4", pulse_cnt - pb, 6);
    check("rs_tdi_bit4", int'(tdi), 1);
    reset_n = 1'b0;
    tick(1);
    check("rs_tck", int'(tck), 0);
    check("rs_tms", int'(tms), 0);
    check("rs_tdi", int'(tdi), 0);
    check("rs_o_pins", int'(o_pins), 0);
    check("rs_busy", int'(busy), 0);
    check("rs_done", int'(done), 0);
    check("rs_error", int'(error), 0);
    reset_n = 1'b1;
    tick(6);
    pb = pulse_cnt; db = done_cnt;
    launch(8'h10, 8'h66);
    wait_done("rs_new", db);
    tick(1);
    check_frame("rs_new", pb, db, 8'h66);

    // start held 3 cycles, re-asserted mid-frame and on the DONE cycle.
    pb = pulse_cnt; db = done_cnt;
    addr = 8'hFF; i_pins = 8'h81;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    i = 0;
    while (pulse_cnt < pb + 10 && i < 2000) begin tick(1); i++; end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("st", db);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("st_not_restarted", int'(busy), 0);
    tick(200);
    check_frame("st", pb, db, 8'h81);

    // CLK_DIV=1 instance with undelayed rtck.
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    i = 0;
    while (done_cnt_f == 0 && i < 2000) begin tick(1); i++; end
    tick(2);
    check("fast_done_count", done_cnt_f, 1);
    check("fast_pulses", pulse_f, FRAME);
    check("fast_min_half_ge3", int'(min_run_f >= 3), 1);
    check("fast_tdi_stable", tdi_bad_f, 0);
    check("fast_o_pins", int'(o_pins_f), 8'hFF);
    check("fast_busy", int'(busy_f), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_master.md
SCAN_MASTER -- requirements
Module: scan_master

Interface
REQ-001 Parameter CLK_DIV, default 4: minimum TCK half-period in clk cycles, range 1..255.
REQ-002 Parameter CHAIN_LEN, default 5: number of TAP stages in the ring; flush TCK count.
REQ-003 Parameter TIMEOUT, default 255: maximum clk cycles to wait for RTCK to follow TCK.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request pulse; accepted only in IDLE.
REQ-007 addr  input  8  target project address.
REQ-008 i_pins  input  8  data sent to the addressed project.
REQ-009 rtck  input  1  returned TCK from the end of the ring; asynchronous.
REQ-010 tdo  input  1  returned serial data from the end of the ring; asynchronous.
REQ-011 tck  output  1  scan clock to the first TAP.
REQ-012 tms  output  1  frame marker to the first TAP.
REQ-013 tdi  output  1  serial data to the first TAP.
REQ-014 o_pins  output  8  data captured from the ring.
REQ-015 busy  output  1  high from start acceptance until return to IDLE.
REQ-016 done  output  1  one-cycle pulse on successful frame completion.
REQ-017 error  output  1  sticky RTCK-timeout flag; cleared by the next accepted start or by reset.

Function
REQ-018 rtck and tdo SHALL each pass through a 2-flop synchronizer before use; no other logic samples the raw pins.
REQ-019 FSM states SHALL be: IDLE, HEADER, ADDR, DATA, FLUSH, TRAILER, DONE.
REQ-020 start in IDLE SHALL latch addr and i_pins, clear error, and set busy on the next cycle; start outside IDLE is ignored.
REQ-021 Each TCK bit SHALL follow this sequence: set tms/tdi; hold tck low CLK_DIV cycles; drive tck high; wait for synced rtck high; hold CLK_DIV cycles; drive tck low; wait for synced rtck low.
REQ-022 tms/tdi SHALL change only while tck is low and the previous bit's synced rtck is low.
REQ-023 HEADER SHALL send 1 bit: tms=1, tdi=1.
REQ-024 ADDR SHALL send 8 bits: tms=0, tdi=addr LSB first.
REQ-025 DATA SHALL send 8 bits: tms=0, tdi=i_pins LSB first.
REQ-026 FLUSH SHALL send CHAIN_LEN bits: tms=0, tdi=0.
REQ-027 TRAILER SHALL send 1 bit: tms=1, tdi=0.
REQ-028 A frame SHALL total 18+CHAIN_LEN TCK pulses.
REQ-029 On each synced-rtck rising edge in DATA or FLUSH, synced tdo SHALL shift into an 8-bit capture register MSB-in (right shift), so the last 8 samples form the byte LSB first.
REQ-030 On entering TRAILER, the capture register SHALL be copied to o_pins; o_pins holds that value until the next frame's TRAILER.
REQ-031 DONE SHALL last exactly one cycle: done=1 and busy=1; the next cycle is IDLE with busy=0.
REQ-032 A wait-for-rtck counter SHALL reset at every tck edge; reaching TIMEOUT sets error, forces tck=0, tms=0, tdi=0, skips DONE, and returns to IDLE with no done pulse and o_pins unchanged.
REQ-033 The bit counter SHALL be wide enough for max(8, CHAIN_LEN) and SHALL reset on every state change.
REQ-034 start asserted in the same cycle DONE exits SHALL be ignored; it is accepted only once IDLE is reached.

Reset
REQ-035 reset_n low at any clk edge, including mid-frame, SHALL within one cycle force state IDLE and tck=0, tms=0, tdi=0, o_pins=0, busy=0, done=0, error=0, and clear synchronizers and counters.
REQ-036 After reset_n rises, the first start SHALL begin a complete new frame; there is no partial resumption.

Verification
REQ-037 Bench ring model: tdi delayed by CHAIN_LEN TCK rising edges; rtck = tck delayed 3 clk. Stimulus start, addr=8'h01, i_pins=8'hA5 -> 23 TCK pulses, first with tms=1/tdi=1, last with tms=1, done pulses once, o_pins=8'hA5, error=0.
REQ-038 Model ring with inversion, i_pins=8'h3C -> o_pins=8'hC3.
REQ-039 rtck stuck low -> error=1 at TIMEOUT cycles after the first tck rise; busy=0; no done; tck=0.
REQ-040 reset_n pulsed low during ADDR bit 4 -> all outputs zero next cycle; a new start then completes a full 23-pulse frame.
REQ-041 start held high for 3 cycles, and start asserted during the frame -> exactly one frame and one done.
REQ-042 CLK_DIV=1, rtck delay 0 synced -> each tck half-period is at least 3 clk cycles (1 hold + 2 synchronizer), and tdi is stable across every tck rising edge.
